serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning operand/result width in bits; legal values are multiples of 4 that are at least 4, and NSLICE = WIDTH/4.
REQ-002 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The module SHALL have port start  input  1  request to begin an operation.
REQ-005 The module SHALL have port sub  input  1  mode select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 The module SHALL have port a  input  WIDTH  first operand (minuend); sampled with start.
REQ-007 The module SHALL have port b  input  WIDTH  second operand (subtrahend); sampled with start.
REQ-008 The module SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 The module SHALL have port done  output  1  one-cycle pulse marking the result as valid.
REQ-010 The module SHALL have port result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-011 The module SHALL have port cb  output  1  carry-out on add, or borrow on subtract.
REQ-012 The module SHALL have port ovf  output  1  signed two's-complement overflow flag (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b and sub, clear the slice counter, set the internal carry to sub, and enter RUN.
REQ-015 In RUN, each rising edge SHALL process one 4-bit slice, LSB slice first: {carry, result[4k+3:4k]} = a_slice + (sub ? ~b_slice : b_slice) + carry.
REQ-016 After the edge that processes slice NSLICE-1, the FSM SHALL enter DONE; DONE SHALL return to IDLE on the next edge unless start is accepted on that edge.
REQ-017 busy SHALL equal (state==RUN).
REQ-018 done SHALL equal (state==DONE), so it is high for exactly one cycle, NSLICE edges after the capture edge.
REQ-019 On the completion edge, cb SHALL be set to the final carry when sub=0 and to the inverted final carry (borrow) when sub=1.
REQ-020 result, cb and ovf SHALL be valid while done=1 and held until the next accepted start.
REQ-021 result bits of slices not yet processed are don't-care during RUN.
REQ-022 start SHALL be ignored while busy=1, with no effect on state, operands or outputs.
REQ-023 Operands changing after the capture edge SHALL NOT affect the operation in progress.
REQ-024 With WIDTH=4, RUN SHALL last exactly one cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, result=0, cb=0, ovf=0, and clear the slice counter and internal carry.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse SHALL follow, and the first edge after release with start=1 SHALL begin a new operation normally.

Configuration
REQ-027 With macro SERIAL_ADDSUB_OVF_EN defined, on the completion edge ovf SHALL be set to (a[W-1] == b_eff[W-1]) && (result[W-1] != a[W-1]), where b_eff = sub ? ~b : b.
REQ-028 Without SERIAL_ADDSUB_OVF_EN, the port ovf SHALL still exist, be driven constant 0, and no overflow logic SHALL be synthesised.

Verification (WIDTH=16 unless stated)
REQ-029 Add 0x1234 + 0x0FFF -> result 0x2233, cb=0; busy high for 4 cycles; done one cycle, 4 edges after capture.
REQ-030 Subtract 0x0005 - 0x0007 -> result 0xFFFE, cb=1 (borrow); subtract 0x00A0 - 0x00A0 -> result 0x0000, cb=0.
REQ-031 Add 0xFFFF + 0x0001 -> result 0x0000, cb=1; add 0x7FFF + 0x0001 -> result 0x8000, ovf=1 with SERIAL_ADDSUB_OVF_EN, ovf=0 without.
REQ-032 start pulsed with new operands during RUN -> ignored; original result returned; back-to-back start during DONE -> accepted with no idle cycle.
REQ-033 rst_n pulled low at the second RUN cycle -> outputs immediately 0, no done; after release, 0x0001 + 0x0002 -> 0x0003.
REQ-034 WIDTH=4: 0x9 - 0xA -> result 0xF, cb=1; done 1 edge after capture.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial (4-bit slice per cycle) adder/subtractor with carry/borrow flag.
// Define SERIAL_ADDSUB_OVF_EN to build the signed overflow flag; otherwise ovf is tied to 0.
module serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cb,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_sub;
    logic             r_cb;

    logic [4:0]       w_sum;
    logic             w_last;

    // Operands shift right each slice, so the current slice is always in bits [3:0].
    assign w_sum  = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'd0, r_carry};
    assign w_last = (r_cnt == CW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_cb     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_sub   <= sub;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_sum[4];
                    r_cnt   <= r_cnt + 1'b1;
                    for (int k = 0; k < NSLICE; k++) begin
                        if (r_cnt == CW'(k)) begin
                            r_result[4*k +: 4] <= w_sum[3:0];
                        end
                    end
                    if (w_last) begin
                        r_cb    <= w_sum[4] ^ r_sub;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic r_ovf;

    // On the last slice r_a[3]/r_b[3] still hold the operand sign bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= (r_a[3] == r_b[3]) && (w_sum[3] != r_a[3]);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cb     = r_cb;

endmodule
